// File: rtl/store_write_buffer.sv
// Write-through store buffer: queues D-cache stores in a circular FIFO, drains them
// to memory over a req/ack handshake and offers a youngest-match lookup for read misses.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [AW-1:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    output logic                     full,
    output logic                     empty,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_data,
    input  logic                     mem_ack,
    input  logic [AW-1:0]            lookup_addr,
    output logic                     lookup_hit,
    output logic [DW-1:0]            lookup_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [AW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];

    logic            pop;
    logic            push_ok;
    logic            unused_lookup_lsb;

    assign unused_lookup_lsb = lookup_addr[0];

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign mem_req = (state_q == BUSY);

    // A full buffer can still accept a store when the head retires in the same cycle.
    assign pop     = (state_q == BUSY) && mem_ack;
    assign push_ok = push && (!full || pop);

    assign mem_addr = empty ? '0 : addr_q[head_q];
    assign mem_data = empty ? '0 : data_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;

        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push_ok) begin
            tail_d = tail_q + PW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end

        // GAP re-evaluates on the post-edge count so a push during GAP is never stranded.
        unique case (state_q)
            IDLE: if (count_d != '0) state_d = BUSY;
            BUSY: if (mem_ack)       state_d = GAP;
            GAP:  state_d = (count_d != '0) ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx][AW-1:1] == lookup_addr[AW-1:1])) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: drain order, full/drop, push-with-pop,
// youngest-match lookup, stray acks and asynchronous reset mid-write.
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic [DW-1:0] push_data = '0;
    logic          full, empty, mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] lookup_addr = '0;
    logic          lookup_hit;
    logic [DW-1:0] lookup_data;
    logic [$clog2(DEPTH):0] count;

    int errors = 0;
    int checks = 0;

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .push_data(push_data),
        .full(full), .empty(empty), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ack(mem_ack), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
        .lookup_data(lookup_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        push = 1'b1; push_addr = a; push_data = d;
        step();
        push = 1'b0;
    endtask

    // Head must be on the bus; ack it, then expect exactly one GAP cycle.
    task automatic ack_head(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        #1;
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_data"}, 32'(mem_data), 32'(d));
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        chk({tag, "_gap"}, 32'(mem_req), 32'd0);
        step();
    endtask

    logic [AW-1:0] ea [5];
    logic [DW-1:0] ed [5];

    initial begin
        // Reset state
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_hit", 32'(lookup_hit), 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        chk("rst_mdata", 32'(mem_data), 32'd0);
        chk("rst_ldata", 32'(lookup_data), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Single store
        do_push(16'h0010, 16'hBEEF);
        chk("t1_empty", 32'(empty), 32'd0);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_req", 32'(mem_req), 32'd1);
        repeat (3) step();
        chk("t1_hold_addr", 32'(mem_addr), 32'h0010);
        ack_head("t1", 16'h0010, 16'hBEEF);
        chk("t1_idle_req", 32'(mem_req), 32'd0);
        chk("t1_idle_empty", 32'(empty), 32'd1);
        chk("t1_idle_count", 32'(count), 32'd0);

        // Fill, drop on full, drain in order
        for (int i = 0; i < 4; i++) begin
            ea[i] = 16'h0020 + 16'(2 * i);
            ed[i] = 16'h1111 * 16'(i + 1);
            do_push(ea[i], ed[i]);
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd4);
        do_push(16'h0028, 16'h9999);
        chk("t2_drop_count", 32'(count), 32'd4);
        chk("t2_drop_head", 32'(mem_data), 32'h1111);
        for (int i = 0; i < 4; i++) begin
            ack_head($sformatf("t2_d%0d", i), ea[i], ed[i]);
            chk($sformatf("t2_cnt%0d", i), 32'(count), 32'(3 - i));
        end
        chk("t2_idle_req", 32'(mem_req), 32'd0);

        // Push into full buffer in the same cycle as ack
        for (int i = 0; i < 4; i++) do_push(ea[i], ed[i]);
        ea[4] = 16'h0030; ed[4] = 16'h5555;
        push = 1'b1; push_addr = ea[4]; push_data = ed[4]; mem_ack = 1'b1;
        step();
        push = 1'b0; mem_ack = 1'b0;
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_gap", 32'(mem_req), 32'd0);
        step();
        for (int i = 1; i < 5; i++) ack_head($sformatf("t3_d%0d", i), ea[i], ed[i]);
        chk("t3_empty", 32'(empty), 32'd1);

        // Youngest-match lookup
        do_push(16'h0040, 16'hAAAA);
        do_push(16'h0040, 16'hBBBB);
        lookup_addr = 16'h0041;
        #1;
        chk("t4_hit", 32'(lookup_hit), 32'd1);
        chk("t4_data", 32'(lookup_data), 32'hBBBB);
        lookup_addr = 16'h0042;
        #1;
        chk("t4_miss_hit", 32'(lookup_hit), 32'd0);
        chk("t4_miss_data", 32'(lookup_data), 32'd0);
        lookup_addr = 16'h0041;
        ack_head("t4_a", 16'h0040, 16'hAAAA);
        ack_head("t4_b", 16'h0040, 16'hBBBB);
        #1;
        chk("t4_drained_hit", 32'(lookup_hit), 32'd0);
        chk("t4_drained_data", 32'(lookup_data), 32'd0);

        // Ack while IDLE and while in GAP is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t5_idle_count", 32'(count), 32'd0);
        chk("t5_idle_req", 32'(mem_req), 32'd0);
        chk("t5_idle_empty", 32'(empty), 32'd1);
        do_push(16'h0050, 16'h0101);
        do_push(16'h0052, 16'h0202);
        chk("t5_req", 32'(mem_req), 32'd1);
        chk("t5_head", 32'(mem_addr), 32'h0050);
        mem_ack = 1'b1;
        step();
        chk("t5_gap_req", 32'(mem_req), 32'd0);
        chk("t5_gap_count", 32'(count), 32'd1);
        step();
        mem_ack = 1'b0;
        chk("t5_after_gap_count", 32'(count), 32'd1);
        ack_head("t5_b", 16'h0052, 16'h0202);
        chk("t5_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-BUSY
        do_push(16'h0060, 16'h6666);
        do_push(16'h0062, 16'h6767);
        do_push(16'h0064, 16'h6868);
        chk("t6_pre_count", 32'(count), 32'd3);
        chk("t6_pre_req", 32'(mem_req), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_req", 32'(mem_req), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_full", 32'(full), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        step();
        rst = 1'b1;
        step();
        do_push(16'h0070, 16'h7777);
        chk("t6_new_count", 32'(count), 32'd1);
        ack_head("t6_new", 16'h0070, 16'h7777);
        chk("t6_final_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Write-through store buffer between the D-cache store path and the cache-to-memory arbiter.
- Turns the store direction (cache→memory) into a queued responder-side stream, opposite to the fill FSM's memory→cache reads.
- Accepts D-cache stores at one per cycle into a FIFO and drains them to the multicycle memory with a req/ack handshake.
- Exposes a youngest-match lookup so D-cache read misses never fetch stale memory data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2.
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  D-cache store strobe; enqueue push_addr/push_data.
- push_addr  in  AW  store address.
- push_data  in  DW  store data.
- full  out  1  buffer holds DEPTH entries.
- empty  out  1  buffer holds 0 entries.
- mem_req  out  1  write request to the arbiter.
- mem_addr  out  AW  head-entry address.
- mem_data  out  DW  head-entry data.
- mem_ack  in  1  one-cycle pulse from the arbiter; the head write has completed.
- lookup_addr  in  AW  D-cache miss address to check.
- lookup_hit  out  1  some valid entry matches lookup_addr.
- lookup_data  out  DW  data of the youngest matching entry; 0 when no hit.
- count  out  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, empty=1, full=0, mem_req=0, lookup_hit=0.
  - mem_addr, mem_data and lookup_data read 0; state=IDLE.
  - Deasserting rst takes effect at the next rising edge.
- Storage:
  - Circular FIFO with head/tail pointers of clog2(DEPTH) bits; both pointers wrap modulo DEPTH.
  - count is tracked separately, so full and empty are unambiguous.
- Enqueue:
  - When push=1 and (!full or a pop happens in the same cycle), write at tail and advance tail.
  - When push=1, full=1 and there is no pop, the store is dropped and nothing changes. The D-cache must stall on full.
- Pop: occurs when mem_ack=1 while state=BUSY. The head advances and count decrements.
- Simultaneous push and pop: count is unchanged. Both pointers advance.
- Push and pop on an empty buffer cannot coincide, because mem_req=0 when empty.
- FSM states:
  - IDLE: mem_req=0. Go to BUSY at the edge where count becomes ≥1, so mem_req rises in the cycle after the first push.
  - BUSY: mem_req=1; mem_addr/mem_data show the head entry and stay stable until ack. On mem_ack go to GAP.
  - GAP: exactly one cycle with mem_req=0 (memory turnaround; lets the arbiter serve the I-side). Then go to BUSY if count≥1, else IDLE.
- mem_ack outside BUSY is ignored: no pop, no state change.
- mem_addr/mem_data outside BUSY: show the head entry when not empty, 0 when empty.
- Lookup (combinational):
  - Compare lookup_addr[AW-1:1] against every valid entry (bit 0 ignored; addresses are word-granular).
  - The youngest match, nearest to tail, wins.
  - An entry being popped this cycle still counts as valid for lookup. A same-cycle push is not visible until after the edge.
- Ordering: memory writes issue in strict push order; no coalescing of same-address stores.
- Reset mid-transaction: all entries are discarded and mem_req drops immediately (asynchronously). The arbiter must abandon the in-flight write.
- Each accepted store is acknowledged once. Throughput is at most one store per (memory latency + 1 GAP) cycles.

Test Plan:
- Reset, then a single push (0x0010, 0xBEEF) → empty drops the next cycle; mem_req=1 with mem_addr=0x0010, mem_data=0xBEEF one cycle after the push; mem_ack after 4 cycles → GAP with mem_req=0, then IDLE; empty=1, count=0.
- Push 4 stores (0x0020..0x0026, data 0x1111..0x4444) back to back → full=1, count=4. A fifth push (0x0028) with no ack is dropped. Acks drain the entries in order 0x1111, 0x2222, 0x3333, 0x4444, with one mem_req=0 GAP cycle between each.
- With full=1, push (0x0030, 0x5555) in the same cycle as mem_ack → count stays 4; 0x5555 is drained last.
- Push (0x0040, 0xAAAA) then (0x0040, 0xBBBB); lookup_addr=0x0041 → lookup_hit=1, lookup_data=0xBBBB. After both drain → lookup_hit=0, lookup_data=0.
- Pulse mem_ack while IDLE and while in GAP → count, pointers and state unchanged.
- Assert rst=0 mid-BUSY with 3 entries → mem_req, count and full drop to 0 without waiting for a clock edge. After release, a new push drains normally with mem_addr matching the new store.
